// File: rtl/alu_packet_parser_if.sv
// Byte-stream and operand-stream bundle for alu_packet_parser.
// master = parser side, slave = surrounding datapath / testbench side.
interface alu_packet_parser_if #(
    parameter int OPERAND_WIDTH_P = 32
);
    logic [7:0]                 s_axis_tdata;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [7:0]                 opcode_o;
    logic [OPERAND_WIDTH_P-1:0] operand_o;
    logic                       operand_valid_o;
    logic                       operand_ready_i;
    logic                       operand_last_o;
    logic                       len_err_o;

    modport master (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  operand_ready_i,
        output s_axis_tready,
        output opcode_o,
        output operand_o,
        output operand_valid_o,
        output operand_last_o,
        output len_err_o
    );

    modport slave (
        output s_axis_tdata,
        output s_axis_tvalid,
        output operand_ready_i,
        input  s_axis_tready,
        input  opcode_o,
        input  operand_o,
        input  operand_valid_o,
        input  operand_last_o,
        input  len_err_o
    );
endinterface

// File: rtl/alu_packet_parser.sv
// Frames UART bytes into opcode/length packets and emits little-endian
// operands to the ALU; bad lengths pulse len_err_o and drain the payload.
module alu_packet_parser #(
    parameter int OPERAND_WIDTH_P = 32
) (
    input logic                 clk,
    input logic                 rst,
    alu_packet_parser_if.master bus
);
    localparam int B  = OPERAND_WIDTH_P / 8;
    localparam int IW = (B > 1) ? $clog2(B) : 1;

    localparam logic [15:0]   MIN_LEN   = 16'(4 + B);
    localparam logic [15:0]   LANE_MASK = 16'(B - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(B - 1);

    localparam logic [2:0] ST_OPCODE = 3'd0;
    localparam logic [2:0] ST_RSVD   = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;
    localparam logic [2:0] ST_DRAIN  = 3'd6;

    logic [2:0]                 state;
    logic [7:0]                 opcode;
    logic [7:0]                 len_lo;
    logic [15:0]                rem;
    logic [IW-1:0]              byte_idx;
    logic [OPERAND_WIDTH_P-1:0] operand;
    logic                       valid;
    logic                       last;
    logic                       len_err;

    logic        hs;
    logic [15:0] len_full;
    logic [15:0] len_m4;
    logic        len_ok;

    assign bus.s_axis_tready   = (state != ST_OUT);
    assign bus.opcode_o        = opcode;
    assign bus.operand_o       = operand;
    assign bus.operand_valid_o = valid;
    assign bus.operand_last_o  = last;
    assign bus.len_err_o       = len_err;

    assign hs       = bus.s_axis_tvalid && bus.s_axis_tready;
    assign len_full = {bus.s_axis_tdata, len_lo};
    assign len_m4   = len_full - 16'd4;
    // B is a power of two, so the modulo reduces to a lane mask
    assign len_ok   = (len_full >= MIN_LEN) && ((len_m4 & LANE_MASK) == 16'd0);

    // Packet framing FSM with operand assembly and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OPCODE;
            opcode   <= '0;
            len_lo   <= '0;
            rem      <= '0;
            byte_idx <= '0;
            operand  <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                ST_OPCODE: if (hs) begin
                    opcode <= bus.s_axis_tdata;
                    state  <= ST_RSVD;
                end
                ST_RSVD: if (hs) begin
                    state <= ST_LEN_LO;
                end
                ST_LEN_LO: if (hs) begin
                    len_lo <= bus.s_axis_tdata;
                    state  <= ST_LEN_HI;
                end
                ST_LEN_HI: if (hs) begin
                    byte_idx <= '0;
                    if (len_ok) begin
                        rem   <= len_m4;
                        state <= ST_DATA;
                    end else begin
                        len_err <= 1'b1;
                        if (len_full > 16'd4) begin
                            rem   <= len_m4;
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_OPCODE;
                        end
                    end
                end
                ST_DATA: if (hs) begin
                    for (int i = 0; i < B; i++) begin
                        if (byte_idx == IW'(i)) begin
                            operand[i*8 +: 8] <= bus.s_axis_tdata;
                        end
                    end
                    rem <= rem - 16'd1;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx <= '0;
                        valid    <= 1'b1;
                        last     <= (rem == 16'd1);
                        state    <= ST_OUT;
                    end else begin
                        byte_idx <= byte_idx + IW'(1);
                    end
                end
                ST_OUT: if (bus.operand_ready_i) begin
                    valid <= 1'b0;
                    last  <= 1'b0;
                    state <= last ? ST_OPCODE : ST_DATA;
                end
                ST_DRAIN: if (hs) begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1) begin
                        state <= ST_OPCODE;
                    end
                end
                default: state <= ST_OPCODE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_packet_parser.sv
// Scoreboard bench for alu_packet_parser: expected operands are queued
// as packets are sent and popped when the parser hands an operand over.
module tb_alu_packet_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_packet_parser_if #(.OPERAND_WIDTH_P(32)) bus();

    alu_packet_parser #(.OPERAND_WIDTH_P(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int fails   = 0;
    int err_cnt = 0;
    int op_cnt  = 0;

    logic [32:0] sb[$];
    logic [7:0]  pkt[$];

    task automatic monitor();
        logic [32:0] exp_v;
        forever begin
            @(negedge clk);
            #1;
            if (bus.len_err_o) begin
                err_cnt++;
                checks++;
                if (bus.operand_valid_o !== 1'b0) begin
                    fails++;
                    $display("FAIL err_with_valid: valid=%b required 0",
                             bus.operand_valid_o);
                end
            end
            if (bus.operand_valid_o && bus.operand_ready_i) begin
                op_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_operand: got %h last=%b",
                             bus.operand_o, bus.operand_last_o);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bus.operand_last_o, bus.operand_o} !== exp_v) begin
                        fails++;
                        $display("FAIL operand: got last=%b %h required last=%b %h",
                                 bus.operand_last_o, bus.operand_o,
                                 exp_v[32], exp_v[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        @(negedge clk);
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        g = 0;
        while (bus.s_axis_tready !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout: tready=%b required 1",
                     bus.s_axis_tready);
        end
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        idle(1);
        while ((sb.size() != 0 || bus.operand_valid_o) && g < 300) begin
            @(negedge clk);
            g++;
        end
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d operands outstanding required 0",
                     sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_axis_tvalid   = 1'b0;
        bus.s_axis_tdata    = 8'h00;
        bus.operand_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks += 5;
        if (bus.s_axis_tready !== 1'b1) begin
            fails++; $display("FAIL rst_tready: %b required 1", bus.s_axis_tready);
        end
        if (bus.operand_valid_o !== 1'b0) begin
            fails++; $display("FAIL rst_valid: %b required 0", bus.operand_valid_o);
        end
        if (bus.operand_o !== 32'h0) begin
            fails++; $display("FAIL rst_operand: %h required 0", bus.operand_o);
        end
        if (bus.opcode_o !== 8'h00) begin
            fails++; $display("FAIL rst_opcode: %h required 0", bus.opcode_o);
        end
        if ({bus.operand_last_o, bus.len_err_o} !== 2'b00) begin
            fails++; $display("FAIL rst_flags: %b required 00",
                              {bus.operand_last_o, bus.len_err_o});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int o0 = op_cnt;
        pkt = {8'h01, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'h04, 8'h03, 8'h02, 8'h01};
        sb.push_back({1'b0, 32'h12345678});
        sb.push_back({1'b1, 32'h01020304});
        send_pkt();
        drain();
        checks += 3;
        if (bus.opcode_o !== 8'h01) begin
            fails++; $display("FAIL basic_opcode: %h required 01", bus.opcode_o);
        end
        if (op_cnt - o0 != 2) begin
            fails++; $display("FAIL basic_count: %0d required 2", op_cnt - o0);
        end
        if (bus.s_axis_tready !== 1'b1) begin
            fails++; $display("FAIL basic_idle: tready=%b required 1",
                              bus.s_axis_tready);
        end
    endtask

    task automatic test_backpressure();
        bus.operand_ready_i = 1'b0;
        pkt = {8'h01, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sb.push_back({1'b0, 32'h12345678});
        sb.push_back({1'b1, 32'h01020304});
        send_pkt();
        idle(1);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks += 2;
            if ({bus.operand_valid_o, bus.operand_o} !== {1'b1, 32'h12345678}) begin
                fails++;
                $display("FAIL bp_hold: valid=%b %h required 1 12345678",
                         bus.operand_valid_o, bus.operand_o);
            end
            if (bus.s_axis_tready !== 1'b0) begin
                fails++; $display("FAIL bp_tready: %b required 0", bus.s_axis_tready);
            end
            @(negedge clk);
        end
        bus.operand_ready_i = 1'b1;
        pkt = {8'h04, 8'h03, 8'h02, 8'h01};
        send_pkt();
        drain();
    endtask

    task automatic test_len_err_drain();
        int e0 = err_cnt;
        int o0 = op_cnt;
        pkt = {8'h02, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        idle(3);
        checks += 2;
        if (err_cnt - e0 != 1) begin
            fails++; $display("FAIL drain_err: %0d pulses required 1", err_cnt - e0);
        end
        if (op_cnt - o0 != 0) begin
            fails++; $display("FAIL drain_ops: %0d required 0", op_cnt - o0);
        end
        pkt = {8'h03, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sb.push_back({1'b1, 32'hDEADBEEF});
        send_pkt();
        drain();
        checks++;
        if (op_cnt - o0 != 1) begin
            fails++; $display("FAIL drain_follow: %0d required 1", op_cnt - o0);
        end
    endtask

    task automatic test_short_len();
        int e0 = err_cnt;
        int o0 = op_cnt;
        pkt = {8'h05, 8'h00, 8'h03, 8'h00};
        send_pkt();
        idle(3);
        checks++;
        if (err_cnt - e0 != 1) begin
            fails++; $display("FAIL short_err: %0d pulses required 1", err_cnt - e0);
        end
        pkt = {8'h07};
        send_pkt();
        idle(1);
        checks++;
        if (bus.opcode_o !== 8'h07) begin
            fails++; $display("FAIL short_opcode: %h required 07", bus.opcode_o);
        end
        pkt = {8'h00, 8'h04, 8'h00};
        send_pkt();
        idle(3);
        checks += 2;
        if (err_cnt - e0 != 2) begin
            fails++; $display("FAIL len4_err: %0d pulses required 2", err_cnt - e0);
        end
        if (op_cnt - o0 != 0) begin
            fails++; $display("FAIL short_ops: %0d required 0", op_cnt - o0);
        end
    endtask

    task automatic test_reset_mid();
        int o0 = op_cnt;
        pkt = {8'h08, 8'h00, 8'h0C, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 3;
        if ({bus.s_axis_tready, bus.operand_valid_o} !== 2'b10) begin
            fails++; $display("FAIL mid_rst_hs: tready,valid=%b required 10",
                              {bus.s_axis_tready, bus.operand_valid_o});
        end
        if (bus.operand_o !== 32'h0) begin
            fails++; $display("FAIL mid_rst_operand: %h required 0", bus.operand_o);
        end
        if (bus.opcode_o !== 8'h00) begin
            fails++; $display("FAIL mid_rst_opcode: %h required 0", bus.opcode_o);
        end
        pkt = {8'h09, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        sb.push_back({1'b1, 32'h00000001});
        send_pkt();
        drain();
        checks += 2;
        if (op_cnt - o0 != 1) begin
            fails++; $display("FAIL mid_rst_count: %0d required 1", op_cnt - o0);
        end
        if (bus.opcode_o !== 8'h09) begin
            fails++; $display("FAIL mid_rst_op9: %h required 09", bus.opcode_o);
        end
    endtask

    task automatic add_pkt(input logic [7:0] opc, input int nops);
        logic [15:0] len = 16'(4 + 4 * nops);
        logic [31:0] w;
        pkt.push_back(opc);
        pkt.push_back(8'h00);
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        for (int k = 0; k < nops; k++) begin
            w = $urandom;
            pkt.push_back(w[7:0]);
            pkt.push_back(w[15:8]);
            pkt.push_back(w[23:16]);
            pkt.push_back(w[31:24]);
            sb.push_back({(k == nops - 1), w});
        end
    endtask

    task automatic test_back_to_back();
        int e0 = err_cnt;
        int o0 = op_cnt;
        int total = 0;
        pkt = {};
        for (int p = 0; p < 5; p++) begin
            int n = (p % 3) + 1;
            add_pkt(8'(8'h10 + p), n);
            total += n;
        end
        send_pkt();
        drain();
        checks += 2;
        if (err_cnt - e0 != 0) begin
            fails++; $display("FAIL b2b_err: %0d pulses required 0", err_cnt - e0);
        end
        if (op_cnt - o0 != total) begin
            fails++; $display("FAIL b2b_count: %0d required %0d", op_cnt - o0, total);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_len_err_drain();
        test_short_len();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
